morse_symbol_decoder: RTL and testbench

Sits directly downstream of the key mapping stage and consumes its `key_output` / `key_valid` stream while the system is in Morse mode. It accumulates dit and dah events into a symbol buffer and commits the buffer on PAUSE, ENTER or an inter-letter timeout. Each commit is translated to an ASCII character and handed to the text buffer over a valid/ready handshake. It also suppresses the repeated and alternating `key_valid` pulses that the upstream stage emits while a key is held.

---
 rtl/morse_symbol_decoder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_morse_symbol_decoder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_symbol_decoder.sv
// morse_symbol_decoder: turns the filtered dit/dah/control key stream into
// ASCII characters. Symbols collect in a small buffer. PAUSE, ENTER or an
// inter-letter timeout commits the buffer through a one-cycle Morse lookup.
// The result is held on a valid/ready output until the consumer accepts it.
module morse_symbol_decoder #(
    parameter int REPEAT_GAP  = 4,
    parameter int MAX_SYMBOLS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] key_output,
    input  logic        key_valid,
    input  logic [1:0]  current_mode,
    input  logic [31:0] letter_gap,
    output logic [7:0]  char_out,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        char_error,
    output logic [2:0]  sym_len,
    output logic [5:0]  sym_pattern,
    output logic        busy
);
    localparam int               LOW_W     = (REPEAT_GAP > 0) ? $clog2(REPEAT_GAP + 1) : 1;
    localparam logic [LOW_W-1:0] LOW_ARMED = LOW_W'(REPEAT_GAP);
    localparam logic [2:0]       LEN_MAX   = 3'(MAX_SYMBOLS);

    typedef enum logic [1:0] {ST_COLLECT, ST_LOOKUP, ST_EMIT} state_t;
    typedef enum logic [2:0] {EV_NONE, EV_DIT, EV_DAH, EV_PAUSE, EV_CLEAR, EV_BACK, EV_ENTER} event_t;

    state_t            state, next_state;
    event_t            key_event, accepted;
    logic              in_morse, mode_changed, accept;
    logic [1:0]        prev_mode;
    logic [10:0]       last_code;
    logic [LOW_W-1:0]  low_cnt;
    logic              overflow;
    logic [31:0]       gap_cnt;
    logic              do_push, do_ovf, do_pop, do_clear, gap_inc, load_char;
    logic [7:0]        char_next;
    logic              err_next;
    logic [8:0]        lookup_res;

    // International Morse table; returns {error, ascii}. The pattern is
    // reordered so the first entered symbol is the most significant bit.
    function automatic logic [8:0] morse_lookup(input logic [2:0] len, input logic [5:0] pat);
        logic [5:0] code;
        logic [7:0] ch;
        code = 6'd0;
        for (int i = 0; i < 6; i++) begin
            if (i < int'(len)) code = {code[4:0], pat[i]};
        end
        case ({len, code})
            {3'd2, 6'b01}:    ch = "A";
            {3'd4, 6'b1000}:  ch = "B";
            {3'd4, 6'b1010}:  ch = "C";
            {3'd3, 6'b100}:   ch = "D";
            {3'd1, 6'b0}:     ch = "E";
            {3'd4, 6'b0010}:  ch = "F";
            {3'd3, 6'b110}:   ch = "G";
            {3'd4, 6'b0000}:  ch = "H";
            {3'd2, 6'b00}:    ch = "I";
            {3'd4, 6'b0111}:  ch = "J";
            {3'd3, 6'b101}:   ch = "K";
            {3'd4, 6'b0100}:  ch = "L";
            {3'd2, 6'b11}:    ch = "M";
            {3'd2, 6'b10}:    ch = "N";
            {3'd3, 6'b111}:   ch = "O";
            {3'd4, 6'b0110}:  ch = "P";
            {3'd4, 6'b1101}:  ch = "Q";
            {3'd3, 6'b010}:   ch = "R";
            {3'd3, 6'b000}:   ch = "S";
            {3'd1, 6'b1}:     ch = "T";
            {3'd3, 6'b001}:   ch = "U";
            {3'd4, 6'b0001}:  ch = "V";
            {3'd3, 6'b011}:   ch = "W";
            {3'd4, 6'b1001}:  ch = "X";
            {3'd4, 6'b1011}:  ch = "Y";
            {3'd4, 6'b1100}:  ch = "Z";
            {3'd5, 6'b11111}: ch = "0";
            {3'd5, 6'b01111}: ch = "1";
            {3'd5, 6'b00111}: ch = "2";
            {3'd5, 6'b00011}: ch = "3";
            {3'd5, 6'b00001}: ch = "4";
            {3'd5, 6'b00000}: ch = "5";
            {3'd5, 6'b10000}: ch = "6";
            {3'd5, 6'b11000}: ch = "7";
            {3'd5, 6'b11100}: ch = "8";
            {3'd5, 6'b11110}: ch = "9";
            default:          ch = 8'h00;
        endcase
        return (ch == 8'h00) ? {1'b1, 8'h3F} : {1'b0, ch};
    endfunction

    // Decode the upstream key code into one of the events this block reacts to.
    always_comb begin
        key_event = EV_NONE;
        case (key_output[10:8])
            3'b000: if (key_output[7:0] == 8'h01) key_event = EV_DIT;
            3'b001: if (key_output[7:0] == 8'h01) key_event = EV_DAH;
            3'b100: begin
                case (key_output[7:0])
                    8'h04:   key_event = EV_PAUSE;
                    8'h08:   key_event = EV_CLEAR;
                    8'h10:   key_event = EV_BACK;
                    8'h20:   key_event = EV_ENTER;
                    default: key_event = EV_NONE;
                endcase
            end
            default: key_event = EV_NONE;
        endcase
    end

    // Repeat filter: a new code always passes; the same code only after a
    // long enough key_valid-low run. A mode change re-arms the filter.
    assign in_morse     = (current_mode == 2'b01);
    assign mode_changed = (current_mode != prev_mode);
    assign accept       = in_morse && key_valid && (key_event != EV_NONE) &&
                          (mode_changed || (low_cnt >= LOW_ARMED) || (key_output != last_code));
    assign accepted     = accept ? key_event : EV_NONE;

    // Repeat-filter history: last accepted code and the current low run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_mode <= 2'b00;
            last_code <= 11'd0;
            low_cnt   <= LOW_ARMED;
        end else begin
            prev_mode <= current_mode;
            if (accept) begin
                last_code <= key_output;
                low_cnt   <= '0;
            end else if (mode_changed) begin
                low_cnt <= LOW_ARMED;
            end else if (key_valid) begin
                low_cnt <= '0;
            end else if (low_cnt < LOW_ARMED) begin
                low_cnt <= low_cnt + LOW_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_COLLECT;
        else     state <= next_state;
    end

    assign lookup_res = morse_lookup(sym_len, sym_pattern);

    // Next state and buffer/character strobes. An accepted event beats the
    // gap timeout in the same cycle.
    always_comb begin
        next_state = state;
        do_push    = 1'b0;
        do_ovf     = 1'b0;
        do_pop     = 1'b0;
        do_clear   = 1'b0;
        gap_inc    = 1'b0;
        load_char  = 1'b0;
        char_next  = 8'h00;
        err_next   = 1'b0;
        case (state)
            ST_COLLECT: begin
                if (!in_morse) begin
                    do_clear = 1'b1;
                end else begin
                    case (accepted)
                        EV_DIT, EV_DAH: begin
                            if (sym_len < LEN_MAX) do_push = 1'b1;
                            else                   do_ovf  = 1'b1;
                        end
                        EV_CLEAR: do_clear = 1'b1;
                        EV_BACK: begin
                            if (sym_len != 3'd0) begin
                                do_pop  = 1'b1;
                                gap_inc = 1'b1;
                            end else begin
                                load_char  = 1'b1;
                                char_next  = 8'h08;
                                next_state = ST_EMIT;
                            end
                        end
                        EV_PAUSE, EV_ENTER: begin
                            if (sym_len != 3'd0) begin
                                next_state = ST_LOOKUP;
                            end else begin
                                load_char  = 1'b1;
                                char_next  = (accepted == EV_PAUSE) ? 8'h20 : 8'h0D;
                                next_state = ST_EMIT;
                            end
                        end
                        default: begin
                            if (sym_len != 3'd0) begin
                                if ((letter_gap != 32'd0) && (gap_cnt >= letter_gap)) next_state = ST_LOOKUP;
                                else                                                  gap_inc    = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_LOOKUP: begin
                load_char  = 1'b1;
                do_clear   = 1'b1;
                next_state = ST_EMIT;
                if (overflow) begin
                    char_next = 8'h3F;
                    err_next  = 1'b1;
                end else begin
                    char_next = lookup_res[7:0];
                    err_next  = lookup_res[8];
                end
            end
            ST_EMIT: begin
                if (char_ready) next_state = ST_COLLECT;
            end
            default: next_state = ST_COLLECT;
        endcase
    end

    // Symbol buffer, overflow flag and inter-letter gap counter. The counter
    // restarts at 1 on each symbol so it equals the cycles elapsed since it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_len     <= 3'd0;
            sym_pattern <= 6'd0;
            overflow    <= 1'b0;
            gap_cnt     <= 32'd0;
        end else if (do_clear) begin
            sym_len     <= 3'd0;
            sym_pattern <= 6'd0;
            overflow    <= 1'b0;
            gap_cnt     <= 32'd0;
        end else begin
            if (do_push) begin
                sym_pattern <= sym_pattern | (6'(accepted == EV_DAH) << sym_len);
                sym_len     <= sym_len + 3'd1;
                gap_cnt     <= 32'd1;
            end else if (do_ovf) begin
                overflow <= 1'b1;
                gap_cnt  <= 32'd1;
            end else if (do_pop) begin
                sym_pattern <= sym_pattern & ~(6'd1 << (sym_len - 3'd1));
                sym_len     <= sym_len - 3'd1;
            end
            if (gap_inc && (gap_cnt != 32'hFFFF_FFFF)) gap_cnt <= gap_cnt + 32'd1;
        end
    end

    // Output character register; only reloaded when a new character is formed,
    // so it stays stable for the whole EMIT phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_out   <= 8'h00;
            char_error <= 1'b0;
        end else if (load_char) begin
            char_out   <= char_next;
            char_error <= err_next;
        end
    end

    assign char_valid = (state == ST_EMIT);
    assign busy       = (state != ST_COLLECT);

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// tb_morse_symbol_decoder: directed scenarios and randomized key traffic,
// compared every cycle with a queue-and-string model of Morse decoding.
module tb_morse_symbol_decoder;
    localparam int GAP = 4;
    localparam logic [10:0] K_DIT   = 11'h001;
    localparam logic [10:0] K_DAH   = 11'h101;
    localparam logic [10:0] K_PAUSE = 11'h404;
    localparam logic [10:0] K_CLEAR = 11'h408;
    localparam logic [10:0] K_BACK  = 11'h410;
    localparam logic [10:0] K_ENTER = 11'h420;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] key_output;
    logic        key_valid;
    logic [1:0]  current_mode;
    logic [31:0] letter_gap;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        char_error;
    logic [2:0]  sym_len;
    logic [5:0]  sym_pattern;
    logic        busy;

    always #5 clk = ~clk;

    morse_symbol_decoder #(.REPEAT_GAP(GAP), .MAX_SYMBOLS(6)) dut (
        .clk(clk), .rst(rst), .key_output(key_output), .key_valid(key_valid),
        .current_mode(current_mode), .letter_gap(letter_gap), .char_out(char_out),
        .char_valid(char_valid), .char_ready(char_ready), .char_error(char_error),
        .sym_len(sym_len), .sym_pattern(sym_pattern), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_del    = 0;
    int d0;
    logic [7:0] last_del = 8'h00;

    string morse_tab [0:35] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                                ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                                "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                                "-----", ".----", "..---", "...--", "....-", ".....",
                                "-....", "--...", "---..", "----."};

    // Reference model state: symbols as a queue, phases as flags.
    bit          mq[$];
    bit          m_ovf, m_lookup, m_emit, m_err;
    int          m_since, m_low;
    logic [7:0]  m_char;
    logic [10:0] m_last;
    logic [1:0]  m_prev;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int decode_key(input logic [10:0] k);
        if (k == K_DIT)   return 1;
        if (k == K_DAH)   return 2;
        if (k == K_PAUSE) return 3;
        if (k == K_CLEAR) return 4;
        if (k == K_BACK)  return 5;
        if (k == K_ENTER) return 6;
        return 0;
    endfunction

    function automatic logic [5:0] model_pattern();
        logic [5:0] p = 6'd0;
        foreach (mq[i]) if (mq[i] && i < 6) p[i] = 1'b1;
        return p;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf   = 1'b0;
        m_since = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_lookup = 1'b0;
        m_emit   = 1'b0;
        m_char   = 8'h00;
        m_err    = 1'b0;
        m_low    = GAP;
        m_last   = 11'd0;
        m_prev   = 2'b00;
    endtask

    task automatic model_start_emit(input logic [7:0] c);
        m_char = c;
        m_err  = 1'b0;
        m_emit = 1'b1;
    endtask

    // Translate the queued dit/dah string through the Morse table.
    task automatic model_commit();
        string s;
        int idx;
        s = "";
        foreach (mq[i]) begin
            if (mq[i]) s = {s, "-"};
            else       s = {s, "."};
        end
        idx = -1;
        for (int i = 0; i < 36; i++) if (morse_tab[i] == s) idx = i;
        if (m_ovf || idx < 0) begin
            m_char = 8'h3F;
            m_err  = 1'b1;
        end else begin
            m_char = (idx < 26) ? 8'(65 + idx) : 8'(48 + idx - 26);
            m_err  = 1'b0;
        end
        model_clear();
        m_lookup = 1'b0;
        m_emit   = 1'b1;
    endtask

    // One clock edge of the reference behaviour, using the inputs at the edge.
    task automatic model_edge();
        int kind;
        bit morse, changed, acc;
        if (rst) begin
            model_reset();
            return;
        end
        kind    = decode_key(key_output);
        morse   = (current_mode == 2'b01);
        changed = (current_mode != m_prev);
        acc     = morse && key_valid && (kind != 0) &&
                  (changed || m_low >= GAP || key_output != m_last);
        if (acc) begin
            m_last = key_output;
            m_low  = 0;
        end else if (changed) m_low = GAP;
        else if (key_valid)   m_low = 0;
        else                  m_low++;
        m_prev = current_mode;

        if (m_emit) begin
            if (char_ready) m_emit = 1'b0;
        end else if (m_lookup) begin
            model_commit();
        end else if (!morse) begin
            model_clear();
        end else if (acc && (kind == 1 || kind == 2)) begin
            if (mq.size() < 6) mq.push_back(kind == 2);
            else               m_ovf = 1'b1;
            m_since = 0;
        end else if (acc && kind == 4) begin
            model_clear();
        end else if (acc && kind == 5) begin
            if (mq.size() > 0) begin
                void'(mq.pop_back());
                m_since++;
            end else model_start_emit(8'h08);
        end else if (acc && (kind == 3 || kind == 6)) begin
            if (mq.size() > 0) m_lookup = 1'b1;
            else               model_start_emit((kind == 3) ? 8'h20 : 8'h0D);
        end else if (mq.size() > 0) begin
            m_since++;
            if (letter_gap != 0 && m_since >= int'(letter_gap)) m_lookup = 1'b1;
        end
    endtask

    task automatic compare_all();
        check_val("char_valid", 32'(char_valid), 32'(m_emit));
        check_val("busy", 32'(busy), 32'(m_emit | m_lookup));
        check_val("sym_len", 32'(sym_len), 32'(mq.size()));
        check_val("sym_pattern", 32'(sym_pattern), 32'(model_pattern()));
        if (m_emit) begin
            check_val("char_out", 32'(char_out), 32'(m_char));
            check_val("char_error", 32'(char_error), 32'(m_err));
        end
    endtask

    task automatic cycle();
        if (!rst && char_valid && char_ready) begin
            n_del++;
            last_del = char_out;
        end
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic pulse(input logic [10:0] k, input int idle);
        key_output = k;
        key_valid  = 1'b1;
        cycle();
        key_valid  = 1'b0;
        repeat (idle) cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_char_out"}, 32'(char_out), 32'h0);
        check_val({tag, "_char_valid"}, 32'(char_valid), 32'h0);
        check_val({tag, "_char_error"}, 32'(char_error), 32'h0);
        check_val({tag, "_sym_len"}, 32'(sym_len), 32'h0);
        check_val({tag, "_sym_pattern"}, 32'(sym_pattern), 32'h0);
        check_val({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        model_reset();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    function automatic logic [10:0] pick_key();
        int r = $urandom_range(0, 15);
        if (r <= 4)  return K_DIT;
        if (r <= 8)  return K_DAH;
        if (r <= 10) return K_PAUSE;
        if (r == 11) return K_ENTER;
        if (r == 12) return K_BACK;
        if (r == 13) return K_CLEAR;
        if (r == 14) return 11'h002;
        return 11'($urandom);
    endfunction

    initial begin
        rst          = 1'b1;
        key_output   = 11'd0;
        key_valid    = 1'b0;
        current_mode = 2'b01;
        letter_gap   = 32'd0;
        char_ready   = 1'b1;
        model_reset();
        repeat (3) cycle();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) cycle();

        // DIT DAH PAUSE -> 'A'
        pulse(K_DIT, 10);
        pulse(K_DAH, 10);
        key_output = K_PAUSE; key_valid = 1'b1; cycle(); key_valid = 1'b0;
        check_val("A_lookup_busy", 32'(busy), 32'h1);
        check_val("A_lookup_valid", 32'(char_valid), 32'h0);
        cycle();
        check_val("A_valid", 32'(char_valid), 32'h1);
        check_val("A_char", 32'(char_out), 32'h41);
        check_val("A_err", 32'(char_error), 32'h0);
        repeat (3) cycle();

        // DAH DIT DIT DIT with timeout 100 -> 'B'
        letter_gap = 32'd100;
        pulse(K_DAH, 5);
        pulse(K_DIT, 5);
        pulse(K_DIT, 5);
        pulse(K_DIT, 0);
        repeat (99) cycle();
        check_val("B_pre_valid", 32'(char_valid), 32'h0);
        check_val("B_pre_len", 32'(sym_len), 32'h4);
        cycle();
        check_val("B_lookup_busy", 32'(busy), 32'h1);
        check_val("B_lookup_valid", 32'(char_valid), 32'h0);
        cycle();
        check_val("B_valid", 32'(char_valid), 32'h1);
        check_val("B_char", 32'(char_out), 32'h42);
        cycle();
        check_val("B_len_after", 32'(sym_len), 32'h0);
        letter_gap = 32'd0;
        repeat (3) cycle();

        // Held PAUSE and chattering DAH
        d0 = n_del;
        key_output = K_PAUSE; key_valid = 1'b1;
        repeat (20) cycle();
        key_valid = 1'b0;
        repeat (3) cycle();
        check_val("held_pause_count", 32'(n_del - d0), 32'd1);
        check_val("held_pause_char", 32'(last_del), 32'h20);
        key_output = K_DAH;
        for (int i = 0; i < 20; i++) begin
            key_valid = (i % 2 == 0);
            cycle();
        end
        key_valid = 1'b0;
        cycle();
        check_val("chatter_len", 32'(sym_len), 32'h1);
        check_val("chatter_pat", 32'(sym_pattern), 32'h1);
        pulse(K_PAUSE, 4);
        check_val("chatter_count", 32'(n_del - d0), 32'd2);
        check_val("chatter_char", 32'(last_del), 32'h54);

        // Overflow, then BACK editing
        repeat (7) pulse(K_DIT, 5);
        key_output = K_PAUSE; key_valid = 1'b1; cycle(); key_valid = 1'b0;
        cycle();
        check_val("ovf_char", 32'(char_out), 32'h3F);
        check_val("ovf_err", 32'(char_error), 32'h1);
        repeat (3) cycle();
        pulse(K_DIT, 5);
        pulse(K_DIT, 5);
        pulse(K_BACK, 5);
        check_val("back_len", 32'(sym_len), 32'h1);
        key_output = K_PAUSE; key_valid = 1'b1; cycle(); key_valid = 1'b0;
        cycle();
        check_val("E_char", 32'(char_out), 32'h45);
        check_val("E_err", 32'(char_error), 32'h0);
        repeat (3) cycle();

        // Backpressure in EMIT with a DIT arriving meanwhile
        pulse(K_DIT, 5);
        pulse(K_DAH, 5);
        char_ready = 1'b0;
        key_output = K_PAUSE; key_valid = 1'b1; cycle(); key_valid = 1'b0;
        cycle();
        check_val("bp_valid", 32'(char_valid), 32'h1);
        check_val("bp_char", 32'(char_out), 32'h41);
        key_output = K_DIT; key_valid = 1'b1; cycle(); key_valid = 1'b0;
        repeat (4) cycle();
        check_val("bp_hold_valid", 32'(char_valid), 32'h1);
        check_val("bp_hold_char", 32'(char_out), 32'h41);
        check_val("bp_dropped_len", 32'(sym_len), 32'h0);
        char_ready = 1'b1;
        cycle();
        check_val("bp_done_valid", 32'(char_valid), 32'h0);
        check_val("bp_done_len", 32'(sym_len), 32'h0);
        repeat (3) cycle();

        // Reset mid-EMIT, reset with symbols, and mode exit
        char_ready = 1'b0;
        pulse(K_DIT, 5);
        key_output = K_PAUSE; key_valid = 1'b1; cycle(); key_valid = 1'b0;
        cycle();
        check_val("rst_emit_pre", 32'(char_valid), 32'h1);
        async_reset("rst_emit");
        char_ready = 1'b1;
        pulse(K_DIT, 5);
        pulse(K_DAH, 5);
        pulse(K_DIT, 5);
        check_val("rst_len_pre", 32'(sym_len), 32'h3);
        async_reset("rst_len");
        pulse(K_DIT, 5);
        pulse(K_DAH, 5);
        check_val("mode_len_pre", 32'(sym_len), 32'h2);
        current_mode = 2'b00;
        d0 = n_del;
        cycle();
        check_val("mode_len", 32'(sym_len), 32'h0);
        repeat (5) cycle();
        check_val("mode_no_char", 32'(n_del - d0), 32'd0);
        current_mode = 2'b01;
        repeat (2) cycle();

        // Randomized traffic against the model
        for (int seg = 0; seg < 8; seg++) begin
            case ($urandom_range(0, 3))
                0:       letter_gap = 32'd0;
                1:       letter_gap = 32'd3;
                2:       letter_gap = 32'd8;
                default: letter_gap = 32'd20;
            endcase
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 3) == 0) key_output = pick_key();
                key_valid  = ($urandom_range(0, 2) == 0);
                char_ready = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 99) == 0)
                    current_mode = 2'($urandom_range(0, 3));
                else if (current_mode != 2'b01 && $urandom_range(0, 9) == 0)
                    current_mode = 2'b01;
                rst = ($urandom_range(0, 499) == 0);
                cycle();
            end
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
